imm_mem_stream_loader: RTL and testbench

//  Parametrised immediate memory for the streaming IPPro datapath: DEPTH x DATA_W LUT-RAM with
//  a handshaked burst-load engine on the write side and a synchronous read port with valid flag.

---
 rtl/imm_mem_stream_loader_if.sv | 30 +++
 rtl/imm_mem_stream_loader.sv | 122 ++++++++++++
 tb/tb_imm_mem_stream_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_mem_stream_loader_if.sv
// Load/read bundle for the immediate memory: burst-load handshake plus the PE read port.
interface imm_mem_stream_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              LD_START;
    logic [ADDR_W-1:0] LD_BASE;
    logic [ADDR_W:0]   LD_LEN;
    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_READY;
    logic              LD_BUSY;
    logic              LD_DONE;
    logic              RD_EN;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;

    // Host/DMA and PE side.
    modport master (
        output LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, RD_EN, RD_ADDR,
        input  LD_READY, LD_BUSY, LD_DONE, RD_DATA, RD_VALID
    );

    // Memory / load engine side.
    modport slave (
        input  LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, RD_EN, RD_ADDR,
        output LD_READY, LD_BUSY, LD_DONE, RD_DATA, RD_VALID
    );
endinterface

// File: rtl/imm_mem_stream_loader.sv
// Immediate memory for the streaming datapath: DEPTH x DATA_W LUT-RAM, burst-load engine
// with auto-incrementing (wrapping) write address, and a registered read port with valid.
module imm_mem_stream_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                   WCLK,
    input logic                   RST,
    imm_mem_stream_loader_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_LEN   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W:0]   len_clamped;
    logic              xfer;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] mem [DEPTH];

    // Lengths above DEPTH are illegal; treat them as a full-memory burst.
    always_comb begin
        len_clamped = bus.LD_LEN;
        if (bus.LD_LEN > DEPTH_LEN) begin
            len_clamped = DEPTH_LEN;
        end
    end

    // FSM state register.
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_busy    = 1'b0;
        ld_done    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.LD_START) begin
                    state_next = (bus.LD_LEN == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                xfer     = bus.LD_VALID;
                if (bus.LD_VALID && (remain == ONE_LEN)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ld_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst address and remaining-word counters.
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            wr_addr <= '0;
            remain  <= '0;
        end else if ((state == IDLE) && bus.LD_START) begin
            wr_addr <= bus.LD_BASE;
            remain  <= len_clamped;
        end else if (xfer) begin
            wr_addr <= wr_addr + ONE_ADDR;
            remain  <= remain - ONE_LEN;
        end
    end

    // LUT-RAM write; contents deliberately survive reset.
    always_ff @(posedge WCLK) begin
        if (xfer) begin
            mem[wr_addr] <= bus.LD_DATA;
        end
    end

    // Registered read port; sees the pre-write word on a same-cycle address collision.
    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.RD_EN;
            if (bus.RD_EN) begin
                rd_data <= mem[bus.RD_ADDR];
            end
        end
    end

    assign bus.LD_READY = ld_ready;
    assign bus.LD_BUSY  = ld_busy;
    assign bus.LD_DONE  = ld_done;
    assign bus.RD_DATA  = rd_data;
    assign bus.RD_VALID = rd_valid;
endmodule

// File: tb/tb_imm_mem_stream_loader.sv
// Bench for imm_mem_stream_loader: directed vector table, hand-written burst corner cases,
// and a randomized run against a queue-based behavioural model.
module tb_imm_mem_stream_loader;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    imm_mem_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imm_mem_stream_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .WCLK (clk),
        .RST  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending burst as a queue of target addresses.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_known [DEPTH];
    int unsigned       m_q [$];
    bit                m_load;
    bit                m_done;
    logic [DATA_W-1:0] m_rd;
    bit                m_rd_known;
    bit                m_rv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.LD_START = 1'b0;
        bus.LD_BASE  = '0;
        bus.LD_LEN   = '0;
        bus.LD_VALID = 1'b0;
        bus.LD_DATA  = '0;
        bus.RD_EN    = 1'b0;
        bus.RD_ADDR  = '0;
    endtask

    // Assert reset mid-cycle, check outputs while reset is held, release away from an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.LD_READY), 32'd0);
        check("rst_busy",  32'(bus.LD_BUSY),  32'd0);
        check("rst_done",  32'(bus.LD_DONE),  32'd0);
        check("rst_rvalid", 32'(bus.RD_VALID), 32'd0);
        check("rst_rdata", 32'(bus.RD_DATA),  32'd0);
        m_q.delete();
        m_load     = 1'b0;
        m_done     = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b1;
        m_rv       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_busy", 32'(bus.LD_BUSY), 32'd0);
        rst = 1'b0;
    endtask

    // One clock: compare status against the model, advance model and DUT, compare read port.
    task automatic step();
        int unsigned a;
        int unsigned n;
        bit          next_done;
        check("ld_ready", 32'(bus.LD_READY), 32'(m_load));
        check("ld_busy",  32'(bus.LD_BUSY),  32'(m_load));
        check("ld_done",  32'(bus.LD_DONE),  32'(m_done));
        if (bus.RD_EN) begin
            a          = int'(bus.RD_ADDR);
            m_rv       = 1'b1;
            m_rd       = m_mem[a];
            m_rd_known = m_known[a];
        end else begin
            m_rv = 1'b0;
        end
        next_done = 1'b0;
        if (m_load) begin
            if (bus.LD_VALID) begin
                a          = m_q.pop_front();
                m_mem[a]   = bus.LD_DATA;
                m_known[a] = 1'b1;
                if (m_q.size() == 0) begin
                    m_load    = 1'b0;
                    next_done = 1'b1;
                end
            end
        end else if (!m_done && bus.LD_START) begin
            n = (int'(bus.LD_LEN) > DEPTH) ? DEPTH : int'(bus.LD_LEN);
            if (n == 0) begin
                next_done = 1'b1;
            end else begin
                for (int unsigned i = 0; i < n; i++) begin
                    m_q.push_back((int'(bus.LD_BASE) + i) % DEPTH);
                end
                m_load = 1'b1;
            end
        end
        m_done = next_done;
        @(posedge clk);
        #1;
        check("rd_valid", 32'(bus.RD_VALID), 32'(m_rv));
        if (m_rd_known) begin
            check("rd_data", 32'(bus.RD_DATA), 32'(m_rd));
        end
    endtask

    typedef struct {
        logic              start;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic              e_busy;
        logic              e_done;
        logic              e_rv;
        logic              chk;
        logic [DATA_W-1:0] e_data;
    } vec_t;

    vec_t tv [23];

    initial begin
        int done_cnt;
        logic [DATA_W-1:0] exp_w [4];
        logic [ADDR_W-1:0] exp_a [4];
        logic              pat [7];
        int                k;

        checks = 0;
        errors = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end

        //          start  base   len    valid  data    rd_en  rd_addr  busy  done  rv    chk   e_data
        tv[0]  = '{1'b1, 5'd0,  6'd4, 1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[1]  = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h11, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[2]  = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h22, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[3]  = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h33, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[4]  = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h44, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[5]  = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tv[6]  = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
        tv[7]  = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 8'h33};
        tv[8]  = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 8'h44};
        tv[9]  = '{1'b1, 5'd7,  6'd1, 1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[10] = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h77, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[11] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[12] = '{1'b1, 5'd7,  6'd1, 1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[13] = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h5A, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b1, 8'h77};
        tv[14] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
        tv[15] = '{1'b1, 5'd3,  6'd0, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[16] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[17] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
        tv[18] = '{1'b1, 5'd0,  6'd2, 1'b0, 8'h00, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[19] = '{1'b1, 5'd20, 6'd5, 1'b1, 8'h66, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[20] = '{1'b0, 5'd0,  6'd0, 1'b1, 8'h67, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tv[21] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h66};
        tv[22] = '{1'b0, 5'd0,  6'd0, 1'b0, 8'h00, 1'b1, 5'd1,  1'b0, 1'b0, 1'b1, 1'b1, 8'h67};

        idle_inputs();
        rst = 1'b0;
        #2;
        do_reset();

        // Reads straight after reset: valid one cycle later.
        for (int unsigned i = 0; i < 4; i++) begin
            bus.RD_EN   = 1'b1;
            bus.RD_ADDR = ADDR_W'(i);
            step();
            check("post_rst_rvalid", 32'(bus.RD_VALID), 32'd1);
        end
        idle_inputs();
        step();

        // Directed table: basic burst, collision read-before-write, zero length, ignored start.
        for (int i = 0; i < 23; i++) begin
            bus.LD_START = tv[i].start;
            bus.LD_BASE  = tv[i].base;
            bus.LD_LEN   = tv[i].len;
            bus.LD_VALID = tv[i].valid;
            bus.LD_DATA  = tv[i].data;
            bus.RD_EN    = tv[i].rd_en;
            bus.RD_ADDR  = tv[i].rd_addr;
            step();
            check($sformatf("tv%0d_busy", i), 32'(bus.LD_BUSY), 32'(tv[i].e_busy));
            check($sformatf("tv%0d_done", i), 32'(bus.LD_DONE), 32'(tv[i].e_done));
            check($sformatf("tv%0d_rv", i), 32'(bus.RD_VALID), 32'(tv[i].e_rv));
            if (tv[i].chk) begin
                check($sformatf("tv%0d_rdata", i), 32'(bus.RD_DATA), 32'(tv[i].e_data));
            end
        end
        idle_inputs();
        step();

        // Wrapping burst with valid gaps: exactly one done pulse, busy held through stalls.
        exp_w[0] = 8'hA1; exp_w[1] = 8'hA2; exp_w[2] = 8'hA3; exp_w[3] = 8'hA4;
        exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0;  exp_a[3] = 5'd1;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 5'd30;
        bus.LD_LEN   = 6'd4;
        step();
        bus.LD_START = 1'b0;
        done_cnt = 0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            bus.LD_VALID = pat[i];
            bus.LD_DATA  = pat[i] ? exp_w[k] : 8'hEE;
            step();
            if (pat[i]) k++;
            if (k < 4) check("wrap_busy_held", 32'(bus.LD_BUSY), 32'd1);
            if (bus.LD_DONE) done_cnt++;
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.LD_DONE) done_cnt++;
        end
        check("wrap_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.RD_EN   = 1'b1;
            bus.RD_ADDR = exp_a[i];
            step();
            check($sformatf("wrap_rd%0d", i), 32'(bus.RD_DATA), 32'(exp_w[i]));
        end
        idle_inputs();
        step();

        // Reset after two of four words: abort with no done, written words retained.
        bus.LD_START = 1'b1;
        bus.LD_BASE  = 5'd10;
        bus.LD_LEN   = 6'd4;
        step();
        bus.LD_START = 1'b0;
        bus.LD_VALID = 1'b1;
        bus.LD_DATA  = 8'hC1;
        step();
        bus.LD_DATA  = 8'hC2;
        step();
        idle_inputs();
        check("abort_busy_before", 32'(bus.LD_BUSY), 32'd1);
        do_reset();
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.LD_DONE) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        bus.RD_EN   = 1'b1;
        bus.RD_ADDR = 5'd10;
        step();
        check("abort_rd10", 32'(bus.RD_DATA), 32'hC1);
        bus.RD_ADDR = 5'd11;
        step();
        check("abort_rd11", 32'(bus.RD_DATA), 32'hC2);
        idle_inputs();
        step();

        // Randomized traffic, including oversize lengths and starts outside idle.
        for (int i = 0; i < 1500; i++) begin
            bus.LD_START = ($urandom_range(0, 3) == 0);
            bus.LD_BASE  = ADDR_W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                bus.LD_LEN = (ADDR_W+1)'($urandom_range(0, 2 * DEPTH - 1));
            end else begin
                bus.LD_LEN = (ADDR_W+1)'($urandom_range(0, 6));
            end
            bus.LD_VALID = ($urandom_range(0, 9) < 7);
            bus.LD_DATA  = DATA_W'($urandom);
            bus.RD_EN    = ($urandom_range(0, 9) < 6);
            bus.RD_ADDR  = ADDR_W'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
